conv_core_acc: RTL and testbench
================================

Name: conv_core_acc

Overview:
Parametrised successor of the 5-tap convolution core: N-tap unsigned multiply-accumulate with a fixed two-register pipeline, an explicit valid handshake and synchronous reset.
Adds a row-accumulate mode in which KERNEL_SIZE consecutive valid beats (one kernel row each) are summed internally, producing one full 2-D window result.
Sits in the convolution datapath between the pixel/kernel shift buffers and the result writer; in chain mode it remains drop-in compatible with the existing core cascade.

Parameters:
KERNEL_SIZE, 5, taps per beat and rows per accumulation group (N ≥ 1).
PIX_W, 8, pixel width.
KER_W, 8, kernel coefficient width.
SUB_W, 8, sub-result input width; must satisfy SUB_W ≤ PIX_W+KER_W.
RES_W, PIX_W+KER_W+$clog2(KERNEL_SIZE+1), per-beat sum width (derived, default 19).
ACC_W, RES_W+$clog2(KERNEL_SIZE), output/accumulator width (derived, default 22).

Ports:
i_clk  in  1  clock; all logic on rising edge.
i_rst  in  1  synchronous, active-high reset.
i_valid  in  1  beat qualifier for i_s/i_k/i_sub/i_mode.
i_mode  in  1  0 = chain (per-beat result), 1 = row-accumulate.
i_s  in  KERNEL_SIZE*PIX_W  packed pixels; tap n at [n*PIX_W +: PIX_W].
i_k  in  KERNEL_SIZE*KER_W  packed kernel values, same packing.
i_sub  in  SUB_W  sub-result added once per result.
o_res  out  ACC_W  result, zero-extended in chain mode.
o_valid  out  1  one-cycle pulse per result.
o_busy  out  1  high while an accumulation group is partially filled.

Behaviour:
- Reset (i_rst high at an edge): o_res=0, o_valid=0, o_busy=0, row counter=0, accumulator=0, stage-1 valid=0. Partial groups are discarded. Reset overrides a concurrent i_valid.
- Arithmetic: unsigned throughout. p[n]=s[n]*k[n] (PIX_W+KER_W bits). Beat sum = zero-extended i_sub + Σp, exact in RES_W. Group sum is exact in ACC_W. No overflow possible at any legal parameter set.
- Stage 1 (input sampled at edge E): products, i_sub, v1=i_valid, the group's mode, and the first/last flags are registered.
- Stage 2 (edge E+1): the adder tree produces the beat sum.
  - Chain mode: o_res ← sum; o_valid ← v1. Latency is 2 edges for every valid beat.
  - Accumulate mode: on the first row, acc ← sum; on other rows, acc ← acc+sum. On the last row, o_res ← acc+sum and o_valid ← 1. Otherwise o_valid ← 0.
  - i_sub is added on the first row only; it is ignored on rows 2..N.
- Row counter: 0..KERNEL_SIZE-1. Advances only on accepted beats in accumulate mode; wraps to 0 after the last row.
  - KERNEL_SIZE=1: every accumulate beat is both first and last, so behaviour is identical to chain mode.
- Mode latching: i_mode is sampled only on a valid beat with counter=0. It is held for the whole group; changes mid-group are ignored.
- Gaps: i_valid low inserts bubbles. Counter and acc hold, o_valid=0, o_res holds its last value. Back-to-back beats are accepted every cycle; there is no backpressure.
- o_busy: high when counter≠0 or a stage-1 accumulate beat is still in flight before its group completes.
- Simultaneous events: a group's last-row result and the next group's first beat are accepted in consecutive cycles without loss.

Decomposition:
- Package conv_core_pkg holds:
  - res_w/acc_w width functions;
  - mode enum {MODE_CHAIN, MODE_ACC};
  - default width constants.
- Sub-module conv_adder_tree: combinational N-input plus-sub summation, parametrised on KERNEL_SIZE and widths, instantiated between stage 1 and stage 2.

Test Plan:
1. Chain mode, s={1,2,3,4,5}, k={2,2,2,2,2}, sub=7, single beat → o_res=37 two edges later; o_valid high exactly one cycle.
2. Chain mode, all s=255, k=255, sub=255 → o_res=325380; no truncation.
3. Accumulate mode, five beats with s=all 1, k=all 1, sub=10 on every beat:
   - o_valid stays low for beats 1–4;
   - o_res=35 after beat 5 (sub counted once);
   - o_busy high from beat 1 until the result.
4. Chain mode, random stream of 200 beats with random i_valid gaps → the output sequence matches a reference model in order; o_valid count equals accepted beat count.
5. Accumulate mode, 3 beats then i_rst for one cycle, then 5 beats of s=all 2, k=all 3, sub=0 → single o_res=150; no residue from the aborted group.
6. Accumulate group with i_mode driven to 0 on rows 2–5 → still a single accumulated result. The next group, started with i_mode=0, produces per-beat chain results.

Source files
------------

// File: rtl/conv_core_pkg.sv
// Shared types and width helpers for the convolution core family.
package conv_core_pkg;

    localparam int DEF_KERNEL_SIZE = 5;
    localparam int DEF_PIX_W       = 8;
    localparam int DEF_KER_W       = 8;
    localparam int DEF_SUB_W       = 8;

    typedef enum logic {
        MODE_CHAIN = 1'b0,
        MODE_ACC   = 1'b1
    } mode_e;

    function automatic int res_w(input int n, input int pix_w, input int ker_w);
        return pix_w + ker_w + $clog2(n + 1);
    endfunction

    function automatic int acc_w(input int n, input int pix_w, input int ker_w);
        return res_w(n, pix_w, ker_w) + $clog2(n);
    endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Combinational sum of KERNEL_SIZE products plus one sub-result.
module conv_adder_tree
    import conv_core_pkg::*;
#(
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int PROD_W      = DEF_PIX_W + DEF_KER_W,
    parameter int SUB_W       = DEF_SUB_W,
    parameter int RES_W       = res_w(DEF_KERNEL_SIZE, DEF_PIX_W, DEF_KER_W)
) (
    input  logic [KERNEL_SIZE*PROD_W-1:0] prods,
    input  logic [SUB_W-1:0]              sub,
    output logic [RES_W-1:0]              sum
);

    always_comb begin
        sum = RES_W'(sub);
        for (int unsigned n = 0; n < KERNEL_SIZE; n++) begin
            sum = sum + RES_W'(prods[n*PROD_W +: PROD_W]);
        end
    end

endmodule

// File: rtl/conv_core_acc.sv
// N-tap unsigned MAC with two-register pipeline and optional row accumulation.
module conv_core_acc
    import conv_core_pkg::*;
#(
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int PIX_W       = DEF_PIX_W,
    parameter int KER_W       = DEF_KER_W,
    parameter int SUB_W       = DEF_SUB_W,
    parameter int RES_W       = res_w(KERNEL_SIZE, PIX_W, KER_W),
    parameter int ACC_W       = acc_w(KERNEL_SIZE, PIX_W, KER_W)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_valid,
    input  logic                         i_mode,
    input  logic [KERNEL_SIZE*PIX_W-1:0] i_s,
    input  logic [KERNEL_SIZE*KER_W-1:0] i_k,
    input  logic [SUB_W-1:0]             i_sub,
    output logic [ACC_W-1:0]             o_res,
    output logic                         o_valid,
    output logic                         o_busy
);

    localparam int PROD_W = PIX_W + KER_W;
    localparam int CNT_W  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

    logic [CNT_W-1:0]                     cnt;
    mode_e                                beat_mode;
    logic                                 is_first;
    logic                                 is_last;

    logic [KERNEL_SIZE-1:0][PROD_W-1:0]   prod1;
    logic [SUB_W-1:0]                     sub1;
    logic                                 v1;
    mode_e                                mode1;
    logic                                 first1;
    logic                                 last1;

    logic [RES_W-1:0]                     sum;
    logic [ACC_W-1:0]                     acc;
    logic [ACC_W-1:0]                     beat_total;

    // A non-zero row count can only exist inside an accumulate group, so the
    // group's latched mode is implied by the counter and needs no register.
    always_comb begin
        beat_mode = (cnt != '0) ? MODE_ACC : mode_e'(i_mode);
        is_first  = (cnt == '0);
        is_last   = (cnt == CNT_W'(KERNEL_SIZE - 1));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt    <= '0;
            v1     <= 1'b0;
            mode1  <= MODE_CHAIN;
            first1 <= 1'b0;
            last1  <= 1'b0;
            sub1   <= '0;
            prod1  <= '0;
        end else begin
            v1 <= i_valid;
            if (i_valid) begin
                for (int unsigned n = 0; n < KERNEL_SIZE; n++) begin
                    prod1[n] <= PROD_W'(i_s[n*PIX_W +: PIX_W]) * PROD_W'(i_k[n*KER_W +: KER_W]);
                end
                mode1 <= beat_mode;
                // Chain beats are treated as single-row groups.
                first1 <= (beat_mode == MODE_CHAIN) || is_first;
                last1  <= (beat_mode == MODE_CHAIN) || is_last;
                sub1   <= ((beat_mode == MODE_CHAIN) || is_first) ? i_sub : '0;
                if (beat_mode == MODE_ACC) begin
                    cnt <= is_last ? '0 : cnt + CNT_W'(1);
                end
            end
        end
    end

    conv_adder_tree #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .PROD_W      (PROD_W),
        .SUB_W       (SUB_W),
        .RES_W       (RES_W)
    ) u_tree (
        .prods (prod1),
        .sub   (sub1),
        .sum   (sum)
    );

    always_comb begin
        beat_total = first1 ? ACC_W'(sum) : acc + ACC_W'(sum);
        o_busy     = (cnt != '0) || (v1 && (mode1 == MODE_ACC));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc     <= '0;
            o_res   <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= v1 && last1;
            if (v1) begin
                if (mode1 == MODE_ACC) begin
                    acc <= beat_total;
                end
                if (last1) begin
                    o_res <= beat_total;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_core_acc.sv
// Randomised bench for conv_core_acc against a group-level arithmetic model.
module tb_conv_core_acc;

    localparam int N  = 5;
    localparam int PW = 8;
    localparam int KW = 8;
    localparam int SW = 8;
    localparam int AW = 22;

    logic            i_clk;
    logic            i_rst;
    logic            i_valid;
    logic            i_mode;
    logic [N*PW-1:0] i_s;
    logic [N*KW-1:0] i_k;
    logic [SW-1:0]   i_sub;
    logic [AW-1:0]   o_res;
    logic            o_valid;
    logic            o_busy;

    int n_cmp = 0;
    int n_err = 0;
    int edge_cnt = 0;

    longint got_res[$];
    int     got_edge[$];
    longint exp_res[$];
    int     exp_edge[$];

    int     m_rows;
    bit     m_mode;
    longint m_acc;

    conv_core_acc dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .i_mode  (i_mode),
        .i_s     (i_s),
        .i_k     (i_k),
        .i_sub   (i_sub),
        .o_res   (o_res),
        .o_valid (o_valid),
        .o_busy  (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) edge_cnt <= edge_cnt + 1;

    always @(negedge i_clk) begin
        if (o_valid === 1'b1) begin
            got_res.push_back(longint'(o_res));
            got_edge.push_back(edge_cnt);
        end
    end

    function automatic longint dot(input logic [N*PW-1:0] s, input logic [N*KW-1:0] k);
        longint t = 0;
        for (int n = 0; n < N; n++) t += longint'(s[n*PW +: PW]) * longint'(k[n*KW +: KW]);
        return t;
    endfunction

    function automatic logic [N*PW-1:0] rep(input logic [PW-1:0] x);
        return {N{x}};
    endfunction

    function automatic logic [N*PW-1:0] rnd_vec();
        logic [N*PW-1:0] v;
        for (int n = 0; n < N; n++) v[n*PW +: PW] = PW'($urandom);
        return v;
    endfunction

    // A group is N accepted beats; its mode is whatever the first beat asked for.
    task automatic model_beat(input bit m, input logic [N*PW-1:0] s, input logic [N*KW-1:0] k,
                              input logic [SW-1:0] sub, input int sample_edge);
        if (m_rows == 0) m_mode = m;
        if (!m_mode) begin
            exp_res.push_back(dot(s, k) + longint'(sub));
            exp_edge.push_back(sample_edge + 1);
        end else begin
            if (m_rows == 0) m_acc = dot(s, k) + longint'(sub);
            else             m_acc += dot(s, k);
            m_rows++;
            if (m_rows == N) begin
                exp_res.push_back(m_acc);
                exp_edge.push_back(sample_edge + 1);
                m_rows = 0;
            end
        end
    endtask

    task automatic drive(input bit v, input bit m, input logic [N*PW-1:0] s,
                         input logic [N*KW-1:0] k, input logic [SW-1:0] sub);
        i_valid = v; i_mode = m; i_s = s; i_k = k; i_sub = sub;
        if (v && !i_rst) model_beat(m, s, k, sub, edge_cnt + 1);
        @(posedge i_clk); #1;
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) drive(1'b0, 1'($urandom), rnd_vec(), rnd_vec(), SW'($urandom));
    endtask

    task automatic clear_all();
        got_res.delete(); got_edge.delete(); exp_res.delete(); exp_edge.delete();
        m_rows = 0; m_mode = 1'b0; m_acc = 0;
    endtask

    task automatic pulse_reset();
        i_rst = 1'b1; i_valid = 1'b1; i_mode = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_valid = 1'b0;
        clear_all();
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_valid = 1'b1; i_mode = 1'b1;
        i_s = rnd_vec(); i_k = rnd_vec(); i_sub = SW'($urandom);
        repeat (2) begin @(posedge i_clk); #1; end
        n_cmp++; if (o_res !== '0) begin n_err++; $display("FAIL reset_res got=%0d want=0", o_res); end
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", o_valid); end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", o_busy); end
        i_rst = 1'b0; i_valid = 1'b0;
        clear_all();
        idle(3);
        n_cmp++; if (got_res.size() != 0) begin n_err++; $display("FAIL reset_override got=%0d results want=0", got_res.size()); end
    endtask

    task automatic test_chain_basic();
        logic [N*PW-1:0] s;
        int e;
        clear_all();
        for (int n = 0; n < N; n++) s[n*PW +: PW] = PW'(n + 1);
        e = edge_cnt + 1;
        drive(1'b1, 1'b0, s, rep(8'd2), 8'd7);
        idle(4);
        n_cmp++; if (got_res.size() != 1) begin n_err++; $display("FAIL chain_basic_count got=%0d want=1", got_res.size()); end
        else begin
            n_cmp++; if (got_res[0] != 37) begin n_err++; $display("FAIL chain_basic_res got=%0d want=37", got_res[0]); end
            n_cmp++; if (got_edge[0] != e + 1) begin n_err++; $display("FAIL chain_basic_latency got=%0d want=%0d", got_edge[0], e + 1); end
        end
    endtask

    task automatic test_chain_max();
        clear_all();
        drive(1'b1, 1'b0, rep(8'hFF), rep(8'hFF), 8'hFF);
        idle(3);
        n_cmp++; if (got_res.size() != 1 || got_res[0] != 325380) begin
            n_err++; $display("FAIL chain_max got=%0d (n=%0d) want=325380", got_res.size() ? got_res[0] : -1, got_res.size());
        end
    endtask

    task automatic test_acc_basic();
        clear_all();
        for (int b = 0; b < N; b++) begin
            drive(1'b1, 1'b1, rep(8'd1), rep(8'd1), 8'd10);
            n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL acc_busy beat%0d got=%b want=1", b + 1, o_busy); end
            n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL acc_early_valid beat%0d got=%b want=0", b + 1, o_valid); end
        end
        idle(1);
        n_cmp++; if (o_valid !== 1'b1 || o_res !== AW'(35)) begin n_err++; $display("FAIL acc_res got=%0d/%b want=35/1", o_res, o_valid); end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL acc_busy_end got=%b want=0", o_busy); end
        idle(3);
        n_cmp++; if (got_res.size() != 1) begin n_err++; $display("FAIL acc_count got=%0d want=1", got_res.size()); end
    endtask

    task automatic test_chain_random();
        clear_all();
        for (int b = 0; b < 200; b++) begin
            if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
            drive(1'b1, 1'b0, rnd_vec(), rnd_vec(), SW'($urandom));
        end
        idle(4);
        n_cmp++; if (got_res.size() != 200) begin n_err++; $display("FAIL chain_rand_count got=%0d want=200", got_res.size()); end
        for (int i = 0; i < exp_res.size() && i < got_res.size(); i++) begin
            n_cmp++;
            if (got_res[i] != exp_res[i] || got_edge[i] != exp_edge[i]) begin
                n_err++; $display("FAIL chain_rand[%0d] got=%0d@%0d want=%0d@%0d", i, got_res[i], got_edge[i], exp_res[i], exp_edge[i]);
            end
        end
    endtask

    task automatic test_acc_reset();
        clear_all();
        for (int b = 0; b < 3; b++) drive(1'b1, 1'b1, rnd_vec(), rnd_vec(), SW'($urandom));
        pulse_reset();
        for (int b = 0; b < N; b++) drive(1'b1, 1'b1, rep(8'd2), rep(8'd3), 8'd0);
        idle(4);
        n_cmp++; if (got_res.size() != 1 || got_res[0] != 150) begin
            n_err++; $display("FAIL acc_reset got=%0d (n=%0d) want=150", got_res.size() ? got_res[0] : -1, got_res.size());
        end
    endtask

    task automatic test_mode_latch();
        clear_all();
        drive(1'b1, 1'b1, rnd_vec(), rnd_vec(), SW'($urandom));
        for (int b = 1; b < N; b++) drive(1'b1, 1'b0, rnd_vec(), rnd_vec(), SW'($urandom));
        for (int b = 0; b < 3; b++) drive(1'b1, 1'b0, rnd_vec(), rnd_vec(), SW'($urandom));
        idle(4);
        n_cmp++; if (got_res.size() != 4) begin n_err++; $display("FAIL mode_latch_count got=%0d want=4", got_res.size()); end
        for (int i = 0; i < exp_res.size() && i < got_res.size(); i++) begin
            n_cmp++;
            if (got_res[i] != exp_res[i] || got_edge[i] != exp_edge[i]) begin
                n_err++; $display("FAIL mode_latch[%0d] got=%0d@%0d want=%0d@%0d", i, got_res[i], got_edge[i], exp_res[i], exp_edge[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_all();
        for (int b = 0; b < 80; b++) begin
            drive(1'b1, 1'($urandom), rnd_vec(), rnd_vec(), SW'($urandom));
            if (b > 40 && $urandom_range(4) == 0) idle(1);
        end
        idle(4);
        n_cmp++; if (got_res.size() != exp_res.size()) begin n_err++; $display("FAIL b2b_count got=%0d want=%0d", got_res.size(), exp_res.size()); end
        for (int i = 0; i < exp_res.size() && i < got_res.size(); i++) begin
            n_cmp++;
            if (got_res[i] != exp_res[i] || got_edge[i] != exp_edge[i]) begin
                n_err++; $display("FAIL b2b[%0d] got=%0d@%0d want=%0d@%0d", i, got_res[i], got_edge[i], exp_res[i], exp_edge[i]);
            end
        end
    endtask

    initial begin
        i_rst = 1'b0; i_valid = 1'b0; i_mode = 1'b0; i_s = '0; i_k = '0; i_sub = '0;
        clear_all();
        test_reset();
        test_chain_basic();
        test_chain_max();
        test_acc_basic();
        test_chain_random();
        test_acc_reset();
        test_mode_latch();
        pulse_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
